// File: rtl/ro_arbiter.sv
// ro_arbiter: round-robin readout arbiter for the digitizer front end.
// Picks one channel with a frozen event, raises its readout request, emits a
// one-cycle header strobe (channel id + event number), then paces exactly
// WORDS buffer reads into the downstream FIFO while honouring backpressure.
//
// Handshake: hdr_valid and ro_rd are single-cycle transfer strobes. A word
// (or the header) moves only in a cycle where the arbiter offers it (HEADER
// or READ state) and fifo_ready is high. The arbiter never withdraws an
// offer, and nothing advances in a cycle where fifo_ready is low.
module ro_arbiter #(
    parameter int NCH   = 4,
    parameter int WORDS = 256,
    parameter int EVT_W = 16,
    parameter int CW    = $clog2(NCH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NCH-1:0]   ch_trig,
    input  logic             fifo_ready,
    output logic [NCH-1:0]   ro_request,
    output logic             ro_rd,
    output logic             hdr_valid,
    output logic [CW-1:0]    grant_id,
    output logic [EVT_W-1:0] evt_count,
    output logic             busy
);

    // Word counter must be able to hold WORDS itself (value after last read).
    localparam int WCW = $clog2(WORDS + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_HEADER = 2'd1,
        S_READ   = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [CW-1:0]    r_ptr;
    logic [CW-1:0]    r_grant;
    logic [EVT_W-1:0] r_evt;
    logic [WCW-1:0]   r_wcnt;
    logic             r_gcnt;

    logic             w_found;
    logic [CW-1:0]    w_sel;
    logic [CW-1:0]    w_ptr_nxt;
    logic [CW:0]      w_sum;
    logic [CW-1:0]    w_j;
    logic             w_hdr;
    logic             w_rd;
    logic             w_last_rd;

    // Round-robin search: first set trigger bit at or above r_ptr, wrapping at NCH.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        w_sum   = '0;
        w_j     = '0;
        for (int i = 0; i < NCH; i++) begin
            w_sum = {1'b0, r_ptr} + (CW + 1)'(i);
            if (w_sum >= (CW + 1)'(NCH)) begin
                w_sum = w_sum - (CW + 1)'(NCH);
            end
            w_j = w_sum[CW-1:0];
            if (!w_found && ch_trig[w_j]) begin
                w_found = 1'b1;
                w_sel   = w_j;
            end
        end
    end

    // Pointer moves to the channel just after the winner so it goes last next round.
    always_comb begin
        w_ptr_nxt = (w_sel == CW'(NCH - 1)) ? '0 : w_sel + 1'b1;
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_found)   w_next = S_HEADER;
            S_HEADER: if (w_hdr)     w_next = S_READ;
            S_READ:   if (w_last_rd) w_next = S_DONE;
            S_DONE:   if (r_gcnt)    w_next = S_IDLE;
            default:                 w_next = S_IDLE;
        endcase
    end

    // Output decode: strobes qualified by fifo_ready, everything else from registers.
    always_comb begin
        busy       = (r_state != S_IDLE);
        ro_request = '0;
        if (r_state == S_HEADER || r_state == S_READ) begin
            ro_request = NCH'(1) << r_grant;
        end
        w_hdr     = (r_state == S_HEADER) && fifo_ready;
        w_rd      = (r_state == S_READ) && fifo_ready;
        w_last_rd = w_rd && (r_wcnt == WCW'(WORDS - 1));
        hdr_valid = w_hdr;
        ro_rd     = w_rd;
        grant_id  = r_grant;
        evt_count = r_evt;
    end

    // Grant capture: only IDLE looks at the trigger flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr   <= '0;
            r_grant <= '0;
        end else if (r_state == S_IDLE && w_found) begin
            r_grant <= w_sel;
            r_ptr   <= w_ptr_nxt;
        end
    end

    // Event number advances right after its header has been accepted; wraps silently.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_evt <= '0;
        end else if (w_hdr) begin
            r_evt <= r_evt + 1'b1;
        end
    end

    // Word counter: cleared as the header goes out, counts accepted reads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wcnt <= '0;
        end else if (w_hdr) begin
            r_wcnt <= '0;
        end else if (w_rd) begin
            r_wcnt <= r_wcnt + 1'b1;
        end
    end

    // Guard counter holds DONE for two cycles so the channel sees the request drop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_gcnt <= 1'b0;
        end else if (r_state == S_DONE) begin
            r_gcnt <= ~r_gcnt;
        end else begin
            r_gcnt <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ro_arbiter.sv
// Testbench for ro_arbiter: NCH=4, WORDS=8, EVT_W=4 (small counter to reach the wrap).
module tb_ro_arbiter;

  localparam int NCH   = 4;
  localparam int WORDS = 8;
  localparam int EVT_W = 4;
  localparam int CW    = 2;

  typedef struct {
    int nhdr;
    int hdrbad;
    int id;
    int evt;
    int hcyc;
    int hit;
    int nrd;
    int rdbad;
    int first_rd_it;
    int last_rd_cyc;
    int nreq;
    int ndone;
    int done_cyc;
    logic [3:0] req_or;
    bit to;
  } obs_t;

  // ---------------- clock / reset / DUT ----------------
  logic             clk;
  logic             rst;
  logic [NCH-1:0]   ch_trig;
  logic             fifo_ready;
  logic [NCH-1:0]   ro_request;
  logic             ro_rd;
  logic             hdr_valid;
  logic [CW-1:0]    grant_id;
  logic [EVT_W-1:0] evt_count;
  logic             busy;

  int cyc = 0;
  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  int m_ptr = 0;
  int m_evt = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ro_arbiter #(.NCH(NCH), .WORDS(WORDS), .EVT_W(EVT_W), .CW(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .ch_trig    (ch_trig),
    .fifo_ready (fifo_ready),
    .ro_request (ro_request),
    .ro_rd      (ro_rd),
    .hdr_valid  (hdr_valid),
    .grant_id   (grant_id),
    .evt_count  (evt_count),
    .busy       (busy)
  );

  // ---------------- reference model ----------------
  // First asserted channel scanning upward from p, wrapping at NCH.
  function automatic int rr_pick(input int p, input logic [3:0] m);
    logic [3:0] rot;
    for (int k = 0; k < NCH; k++) begin
      rot = m >> ((p + k) % NCH);
      if (rot[0]) return (p + k) % NCH;
    end
    return -1;
  endfunction

  function automatic void model_grant(input int ch);
    m_ptr = (ch + 1) % NCH;
    m_evt = (m_evt + 1) % (1 << EVT_W);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    ch_trig = '0;
    @(negedge clk);
    rst = 1'b0;
    m_ptr = 0;
    m_evt = 0;
  endtask

  // Runs one grant to completion (until busy falls), driving fifo_ready per
  // mode (0: always high, 1: toggle 1,0,1,... from HEADER entry, 2: random)
  // and recording what the DUT did. Optionally rewrites ch_trig once reads
  // have started and again once DONE is seen.
  task automatic observe_grant(input int mode, input bit chg,
                               input logic [3:0] rd_trig, input logic [3:0] dn_trig,
                               output obs_t o);
    bit started = 1'b0;
    bit rd_seen = 1'b0;
    bit dn_seen = 1'b0;
    int phase = 0;
    o = '{default: 0};
    o.first_rd_it = -1;
    o.to = 1'b1;
    for (int it = 0; it < 200; it++) begin
      @(negedge clk);
      if (chg && rd_seen && !dn_seen) ch_trig = rd_trig;
      if (chg && dn_seen) ch_trig = dn_trig;
      if (!started && busy) begin
        started = 1'b1;
        phase = 0;
      end
      case (mode)
        0: fifo_ready = 1'b1;
        1: fifo_ready = started ? ((phase % 2) == 0) : 1'b1;
        default: fifo_ready = ($urandom_range(0, 3) != 0);
      endcase
      #1;
      if (started && !busy) begin
        o.to = 1'b0;
        break;
      end
      if (started) begin
        if (hdr_valid) begin
          o.nhdr++;
          if (!fifo_ready) o.hdrbad++;
          o.id = int'(grant_id);
          o.evt = int'(evt_count);
          o.hcyc = cyc;
          o.hit = it;
        end
        if (ro_rd) begin
          o.nrd++;
          if (!fifo_ready) o.rdbad++;
          if (o.first_rd_it < 0) o.first_rd_it = it;
          o.last_rd_cyc = cyc;
          rd_seen = 1'b1;
        end
        if (ro_request != '0) begin
          o.nreq++;
          o.req_or = o.req_or | ro_request;
        end else if (o.nhdr > 0) begin
          o.ndone++;
          if (!dn_seen) o.done_cyc = cyc;
          dn_seen = 1'b1;
        end
        phase++;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    fifo_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      ch_trig = 4'($urandom_range(1, 15));
      #1;
      n_checks++; if (ro_request !== 4'b0000) begin n_errors++; $display("FAIL reset_req: got %b expected 0000", ro_request); end
      n_checks++; if (ro_rd !== 1'b0) begin n_errors++; $display("FAIL reset_rd: got %b expected 0", ro_rd); end
      n_checks++; if (hdr_valid !== 1'b0) begin n_errors++; $display("FAIL reset_hdr: got %b expected 0", hdr_valid); end
      n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
      n_checks++; if (grant_id !== 2'd0) begin n_errors++; $display("FAIL reset_grant: got %0d expected 0", grant_id); end
      n_checks++; if (evt_count !== 4'd0) begin n_errors++; $display("FAIL reset_evt: got %0d expected 0", evt_count); end
    end
    @(negedge clk);
    ch_trig = '0;
    rst = 1'b0;
    m_ptr = 0;
    m_evt = 0;
  endtask

  task automatic test_single();
    obs_t o;
    do_reset();
    ch_trig = 4'b0010;
    observe_grant(0, 1'b1, 4'b0000, 4'b0000, o);
    n_checks++; if (o.to !== 1'b0) begin n_errors++; $display("FAIL single_busy_fall: got timeout %0d expected 0", o.to); end
    n_checks++; if (o.nhdr != 1) begin n_errors++; $display("FAIL single_nhdr: got %0d expected 1", o.nhdr); end
    n_checks++; if (o.id != 1) begin n_errors++; $display("FAIL single_id: got %0d expected 1", o.id); end
    n_checks++; if (o.evt != 0) begin n_errors++; $display("FAIL single_evt: got %0d expected 0", o.evt); end
    n_checks++; if (o.hit != 0) begin n_errors++; $display("FAIL single_hdr_latency: got %0d expected 0", o.hit); end
    n_checks++; if (o.first_rd_it != 1) begin n_errors++; $display("FAIL single_rd_latency: got %0d expected 1", o.first_rd_it); end
    n_checks++; if (o.nreq != WORDS + 1) begin n_errors++; $display("FAIL single_req_cycles: got %0d expected %0d", o.nreq, WORDS + 1); end
    n_checks++; if (o.req_or !== 4'b0010) begin n_errors++; $display("FAIL single_req_val: got %b expected 0010", o.req_or); end
    n_checks++; if (o.nrd != WORDS) begin n_errors++; $display("FAIL single_nrd: got %0d expected %0d", o.nrd, WORDS); end
    n_checks++; if (o.ndone != 2) begin n_errors++; $display("FAIL single_done: got %0d expected 2", o.ndone); end
    model_grant(1);
  endtask

  task automatic test_back_to_back();
    obs_t o;
    int prev_h = 0;
    int exp_id;
    do_reset();
    ch_trig = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      exp_id = rr_pick(m_ptr, 4'b1111);
      observe_grant(0, 1'b0, 4'b0000, 4'b0000, o);
      n_checks++; if (o.id != exp_id) begin n_errors++; $display("FAIL b2b_id[%0d]: got %0d expected %0d", g, o.id, exp_id); end
      n_checks++; if (o.evt != m_evt) begin n_errors++; $display("FAIL b2b_evt[%0d]: got %0d expected %0d", g, o.evt, m_evt); end
      if (g > 0) begin
        n_checks++; if (o.hcyc - prev_h != WORDS + 4) begin n_errors++; $display("FAIL b2b_spacing[%0d]: got %0d expected %0d", g, o.hcyc - prev_h, WORDS + 4); end
      end
      prev_h = o.hcyc;
      model_grant(exp_id);
    end
    ch_trig = '0;
  endtask

  task automatic test_backpressure();
    obs_t o;
    int exp_id;
    ch_trig = 4'b0100;
    exp_id = rr_pick(m_ptr, 4'b0100);
    observe_grant(1, 1'b1, 4'b0000, 4'b0000, o);
    n_checks++; if (o.id != exp_id) begin n_errors++; $display("FAIL bp_id: got %0d expected %0d", o.id, exp_id); end
    n_checks++; if (o.evt != m_evt) begin n_errors++; $display("FAIL bp_evt: got %0d expected %0d", o.evt, m_evt); end
    n_checks++; if (o.hit != 0) begin n_errors++; $display("FAIL bp_hdr_len: got %0d expected 0", o.hit); end
    n_checks++; if (o.nrd != WORDS) begin n_errors++; $display("FAIL bp_nrd: got %0d expected %0d", o.nrd, WORDS); end
    n_checks++; if (o.rdbad != 0) begin n_errors++; $display("FAIL bp_rd_when_stalled: got %0d expected 0", o.rdbad); end
    n_checks++; if (o.last_rd_cyc - o.hcyc != 2 * WORDS) begin n_errors++; $display("FAIL bp_read_span: got %0d expected %0d", o.last_rd_cyc - o.hcyc, 2 * WORDS); end
    model_grant(exp_id);
  endtask

  task automatic test_async_reset();
    obs_t o;
    int nrd = 0;
    ch_trig = 4'b0001;
    fifo_ready = 1'b1;
    for (int i = 0; i < 50 && nrd < 3; i++) begin
      @(negedge clk);
      #1;
      if (ro_rd) nrd++;
    end
    n_checks++; if (nrd != 3) begin n_errors++; $display("FAIL arst_reach_rd3: got %0d expected 3", nrd); end
    #1 rst = 1'b1;
    #1;
    n_checks++; if (ro_request !== 4'b0000) begin n_errors++; $display("FAIL arst_req: got %b expected 0000", ro_request); end
    n_checks++; if (ro_rd !== 1'b0) begin n_errors++; $display("FAIL arst_rd: got %b expected 0", ro_rd); end
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL arst_busy: got %b expected 0", busy); end
    @(negedge clk);
    ch_trig = 4'b1000;
    rst = 1'b0;
    m_ptr = 0;
    m_evt = 0;
    observe_grant(0, 1'b1, 4'b0000, 4'b0000, o);
    n_checks++; if (o.id != 3) begin n_errors++; $display("FAIL arst_regrant_id: got %0d expected 3", o.id); end
    n_checks++; if (o.evt != 0) begin n_errors++; $display("FAIL arst_regrant_evt: got %0d expected 0", o.evt); end
    n_checks++; if (o.nrd != WORDS) begin n_errors++; $display("FAIL arst_regrant_nrd: got %0d expected %0d", o.nrd, WORDS); end
    model_grant(3);
  endtask

  task automatic test_trig_change();
    obs_t o1;
    obs_t o2;
    int exp1;
    ch_trig = 4'b0001;
    exp1 = rr_pick(m_ptr, 4'b0001);
    observe_grant(0, 1'b1, 4'b0000, 4'b0100, o1);
    n_checks++; if (o1.id != exp1) begin n_errors++; $display("FAIL trig_first_id: got %0d expected %0d", o1.id, exp1); end
    n_checks++; if (o1.nrd != WORDS) begin n_errors++; $display("FAIL trig_drop_nrd: got %0d expected %0d", o1.nrd, WORDS); end
    model_grant(exp1);
    observe_grant(0, 1'b1, 4'b0000, 4'b0000, o2);
    n_checks++; if (o2.id != 2) begin n_errors++; $display("FAIL trig_next_id: got %0d expected 2", o2.id); end
    n_checks++; if (o2.evt != m_evt) begin n_errors++; $display("FAIL trig_next_evt: got %0d expected %0d", o2.evt, m_evt); end
    n_checks++; if (o2.hcyc - o1.done_cyc != 3) begin n_errors++; $display("FAIL trig_next_timing: got %0d expected 3", o2.hcyc - o1.done_cyc); end
    model_grant(2);
  endtask

  task automatic test_evt_wrap();
    obs_t o;
    do_reset();
    ch_trig = 4'b0010;
    for (int g = 0; g < 17; g++) begin
      observe_grant(2, 1'b0, 4'b0000, 4'b0000, o);
      n_checks++; if (o.id != 1) begin n_errors++; $display("FAIL wrap_id[%0d]: got %0d expected 1", g, o.id); end
      n_checks++; if (o.evt != m_evt) begin n_errors++; $display("FAIL wrap_evt[%0d]: got %0d expected %0d", g, o.evt, m_evt); end
      n_checks++; if (o.nrd != WORDS || o.rdbad != 0) begin n_errors++; $display("FAIL wrap_rd[%0d]: got %0d/%0d expected %0d/0", g, o.nrd, o.rdbad, WORDS); end
      model_grant(1);
    end
    ch_trig = '0;
  endtask

  task automatic test_random();
    obs_t o;
    logic [3:0] mask;
    int exp_id;
    logic [3:0] exp_oh;
    for (int g = 0; g < 20; g++) begin
      mask = 4'($urandom_range(1, 15));
      ch_trig = mask;
      exp_id = rr_pick(m_ptr, mask);
      exp_oh = 4'b0001 << exp_id;
      observe_grant(2, 1'b0, 4'b0000, 4'b0000, o);
      ch_trig = '0;
      n_checks++; if (o.to !== 1'b0 || o.nhdr != 1 || o.hdrbad != 0) begin n_errors++; $display("FAIL rand_hdr[%0d]: got to=%0d nhdr=%0d bad=%0d expected 0/1/0", g, o.to, o.nhdr, o.hdrbad); end
      n_checks++; if (o.id != exp_id) begin n_errors++; $display("FAIL rand_id[%0d]: got %0d expected %0d (mask %b)", g, o.id, exp_id, mask); end
      n_checks++; if (o.evt != m_evt) begin n_errors++; $display("FAIL rand_evt[%0d]: got %0d expected %0d", g, o.evt, m_evt); end
      n_checks++; if (o.req_or !== exp_oh) begin n_errors++; $display("FAIL rand_req[%0d]: got %b expected %b", g, o.req_or, exp_oh); end
      n_checks++; if (o.nrd != WORDS || o.rdbad != 0) begin n_errors++; $display("FAIL rand_rd[%0d]: got %0d/%0d expected %0d/0", g, o.nrd, o.rdbad, WORDS); end
      n_checks++; if (o.ndone != 2) begin n_errors++; $display("FAIL rand_done[%0d]: got %0d expected 2", g, o.ndone); end
      model_grant(exp_id);
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    rst = 1'b1;
    ch_trig = '0;
    fifo_ready = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_async_reset();
    test_trig_change();
    test_evt_wrap();
    do_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ro_arbiter.md
# ro_arbiter

Round-robin readout arbiter for the multi-channel digitizer front end. It watches each channel's "event frozen" flag, which is high while that channel's acquisition state machine sits in TRIGGERED. It grants one channel at a time by driving that channel's readout request, emits a one-cycle header strobe with channel id and event number, then paces exactly WORDS buffer reads into the downstream FIFO under backpressure. It sits between the per-channel acquisition state machines and the shared event FIFO.

## Interface
Parameters:
- NCH, 4: number of digitizer channels (2..16).
- WORDS, 256: samples read per event (1..4096).
- EVT_W, 16: width of the event counter.
- CW, clog2(NCH): width of `grant_id`.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  reset, asynchronous, active-high.
- ch_trig  in  NCH  per-channel level: channel holds a frozen event awaiting readout.
- fifo_ready  in  1  downstream FIFO can accept a word this cycle.
- ro_request  out  NCH  one-hot readout request to the granted channel.
- ro_rd  out  1  read strobe to the granted channel's sample buffer, one word per high cycle.
- hdr_valid  out  1  one-cycle header strobe; `grant_id` and `evt_count` are valid with it.
- grant_id  out  CW  index of the currently or last granted channel.
- evt_count  out  EVT_W  number of the event whose header is being or was last emitted.
- busy  out  1  high in any state other than IDLE.

## Operation
- States: IDLE, HEADER, READ, DONE. State and all counters are registered.
- IDLE:
  - `ch_trig` is sampled here only.
  - If any bit is set, select the first set bit searching upward (with wrap) from `ptr`.
  - Register that index into `grant_id`, set `ptr` to grant+1 mod NCH, then go to HEADER.
  - If no bit is set, stay in IDLE.
- HEADER:
  - `ro_request[grant_id]` is high, giving the channel one cycle of lead before reads.
  - `hdr_valid` = HEADER && fifo_ready.
  - On `hdr_valid`, go to READ and clear the word counter.
  - Otherwise hold in HEADER.
- READ:
  - `ro_request[grant_id]` stays high.
  - `ro_rd` = READ && fifo_ready.
  - Word counter (clog2(WORDS+1) bits) increments on each `ro_rd`.
  - When `ro_rd` is high with count == WORDS-1, go to DONE.
  - Exactly WORDS `ro_rd` pulses are issued per grant.
- DONE:
  - `ro_request` is all zero.
  - Lasts exactly 2 cycles (counted by a guard counter) so the channel state machine sees the request drop and leaves readout.
  - Then go to IDLE.
  - Consequence: a channel re-asserting `ch_trig` is not re-granted earlier than the IDLE cycle that follows.
- `evt_count`:
  - The value shown on `hdr_valid` is the current count.
  - The count increments by 1 in the cycle after `hdr_valid`.
  - Wraps from 2^EVT_W-1 to 0 with no flag.
- `ch_trig` changes outside IDLE are ignored. A channel whose flag drops before IDLE samples it is simply not granted. A grant, once made, always completes.
- Simultaneous requests: round-robin guarantees every asserted channel is granted within NCH grants.
- Unused `ch_trig` bits (when NCH is not a power of 2) do not exist; `ptr` wraps at NCH.

## Timing
- Reset values: state IDLE, `ptr`=0, `grant_id`=0, `evt_count`=0, word counter 0; `ro_request`=0, `ro_rd`=0, `hdr_valid`=0, `busy`=0.
- Reset takes effect immediately. Asserting reset mid-READ drops `ro_request` and `ro_rd` without waiting for a clock edge.
- Latency: `ch_trig` is high at rising edge k in IDLE → HEADER in cycle k+1, with `ro_request` high and `hdr_valid` high that cycle if `fifo_ready` is high.
  - The first `ro_rd` comes no earlier than cycle k+2.
- With `fifo_ready` held high, one grant spans:
  - 1 HEADER cycle, WORDS READ cycles and 2 DONE cycles, then 1 IDLE cycle.
  - WORDS+4 cycles between consecutive headers.
- `ro_rd` and `hdr_valid` are combinational from registered state AND `fifo_ready`. All other outputs are decoded from registers only.

## Test plan
- NCH=4, WORDS=8, `ch_trig`=0010, `fifo_ready`=1 → `hdr_valid` 1 cycle with `grant_id`=1 and `evt_count`=0; `ro_request`=0010 for 9 cycles; 8 `ro_rd` pulses; 2 DONE cycles; `busy` then falls.
- `ch_trig`=1111 held, `fifo_ready`=1 → header `grant_id` sequence 0,1,2,3,0 and `evt_count` 0,1,2,3,4, with headers 12 cycles apart.
- `fifo_ready` toggling 1,0,1,0 from HEADER entry → HEADER lasts 1 cycle; exactly 8 `ro_rd` pulses, each only when `fifo_ready`=1; READ spans 16 cycles.
- `rst` asserted asynchronously after the 3rd `ro_rd` → `ro_request`, `ro_rd` and `busy` go to 0 before the next edge. After release, `ch_trig`=1000 grants channel 3 with `evt_count`=0.
- EVT_W=4, one channel triggering 17 times → 16th header shows `evt_count`=15, 17th shows 0.
- `ch_trig`=0001 dropped during READ and `ch_trig`=0100 raised in DONE → channel 0 still receives all 8 reads; next grant is channel 2 in the IDLE cycle after DONE.
